regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised integer register file for the pipelined core: NREAD combinational read ports,
//  two write-back ports (ALU/load path and CSR path) and a per-register scoreboard of pending
//  writes. Sits between decode (reads, issue) and write-back; rd_hazard drives the decode stall.
// PARAMETERS
//  XLEN   32  data width of each register
//  NREGS  32  number of architectural registers; x0 hard-wired to zero, power of two >= 2
//  NREAD  2   number of read ports, 1..4
//  AW     $clog2(NREGS)  address width (derived, do not override)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous, active-high reset
//  rd_addr    in   NREAD*AW    read addresses, port i at [i*AW +: AW]
//  rd_data    out  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN]
//  rd_hazard  out  NREAD       port i reads a register with a pending, unresolved write
//  wa_en      in   1           write port A enable (dmem / ALU / PC+4 result)
//  wa_addr    in   AW          write port A destination
//  wa_data    in   XLEN        write port A data
//  wb_en      in   1           write port B enable (CSR read result)
//  wb_addr    in   AW          write port B destination
//  wb_data    in   XLEN        write port B data
//  iss_en     in   1           instruction with a destination issued this cycle
//  iss_addr   in   AW          its destination register
//  flush      in   1           pipeline flush: discard all pending-write marks
//  busy_cnt   out  AW+1        number of registers currently marked pending
// BEHAVIOUR
//  - Reset (async): all registers = 0, all busy bits = 0, busy_cnt = 0; rd_data reads 0,
//    rd_hazard = 0. Reset asserted mid-operation discards any in-flight write.
//  - Writes: registered on rising clk. Address 0 ignored on both ports. wa_addr == wb_addr with
//    both enabled: port B wins, port A dropped.
//  - Reads: combinational, zero latency. rd_addr == 0 -> 0, never hazard.
//  - Scoreboard, one busy bit per register, updated each rising clk:
//    clear if (wa_en && wa_addr==r) || (wb_en && wb_addr==r); set if iss_en && iss_addr==r.
//    Set and clear of the same register in one cycle -> stays busy (newer producer wins).
//    Issue to x0 ignored. flush clears all bits; flush beats a same-cycle iss_en.
//  - busy_cnt: registered population count of busy bits, range 0..NREGS-1. Updated with a
//    net delta per cycle (+1 set, -1 per cleared distinct register); no wrap by construction.
//    flush -> 0 next cycle.
//  - rd_hazard[i] = busy[rd_addr_i] && !(bypass hit on rd_addr_i, see CONFIGURATION).
//  - Write to a non-busy register is legal (e.g. post-flush drain); it updates data, busy stays 0.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-through. If a read address matches an enabled, non-zero write
//    address in the same cycle, rd_data returns the write data (port B over port A) and
//    rd_hazard is 0 for that port.
//  Not defined: rd_data is always the stored value. rd_hazard stays asserted during the
//    write-back cycle and drops the cycle after; one extra stall cycle per RAW dependence.
// TESTING
//  1 Reset: rst=1 for 2 cycles while wa_en=1, wa_addr=5 -> after release, x5 reads 0,
//    busy_cnt=0, rd_hazard=0.
//  2 Write/read: wa_en, x7=32'hDEAD_BEEF; next cycle rd_addr0=7 -> rd_data0=32'hDEADBEEF;
//    write x0=32'h1 -> x0 still reads 0.
//  3 Dual-write collision: wa x9=32'h1111, wb x9=32'h2222 same cycle -> x9=32'h2222;
//    with REGFILE_BYPASS_EN the same-cycle read of x9 also returns 32'h2222.
//  4 Scoreboard: iss x3 -> next cycle busy_cnt=1, read x3 hazard=1; wa x3=32'h5 -> hazard 0
//    same cycle with bypass (data 32'h5), one cycle later without; busy_cnt returns to 0.
//  5 Set+clear race: x4 busy; same cycle wa x4 and iss x4 -> x4 still busy, busy_cnt unchanged.
//  6 Flush: iss x1,x2,x3 on consecutive cycles; flush with iss x6 -> all busy 0, busy_cnt=0.

Source files
------------

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   Integer register file for the pipelined core with a pending-write
//   scoreboard. Decode reads operands through NREAD combinational ports and
//   marks the destination of each issued instruction as busy. Write-back
//   retires those marks through two write ports. rd_hazard tells decode which
//   read ports currently see a register whose producer has not written back.
//
// Parameters
//   XLEN   data width of each register
//   NREGS  number of architectural registers (power of two, x0 reads zero)
//   NREAD  number of read ports (1..4)
//   AW     address width, derived from NREGS (do not override)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   rd_addr    packed read addresses, port i at [i*AW +: AW]
//   rd_data    packed read data, port i at [i*XLEN +: XLEN]
//   rd_hazard  per read port: operand has a pending, unresolved write
//   wa_*       write port A (ALU / load / PC+4 result)
//   wb_*       write port B (CSR read result), wins over A on same address
//   iss_en     an instruction with a destination issues this cycle
//   iss_addr   destination of that instruction
//   flush      discard every pending-write mark
//   busy_cnt   number of registers currently marked busy
//
// Configuration
//   REGFILE_BYPASS_EN  when defined, a read that matches a same-cycle write
//                      returns the write data and reports no hazard. When
//                      undefined, reads always return the stored value and
//                      the hazard drops one cycle after write-back.
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_hazard,
    input  logic                  wa_en,
    input  logic [AW-1:0]         wa_addr,
    input  logic [XLEN-1:0]       wa_data,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    input  logic                  flush,
    output logic [AW:0]           busy_cnt
);

    localparam int CW = AW + 1;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] busy_next;
    logic [CW-1:0]    busy_cnt_next;
    logic             inc;
    logic [1:0]       dec;

    // Scoreboard next-state. Issue marks a register busy, a write-back on
    // either port clears it, and an issue in the same cycle as a clear keeps
    // it busy because the newly issued producer is the one that matters.
    // x0 is never marked. The count is kept incrementally: at most one
    // register can become busy (a fresh issue to a non-busy register) and at
    // most two can retire (one per write port), so the delta is bounded and
    // the counter never wraps. Flush overrides everything, including issue.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int r = 1; r < NREGS; r++) begin
            set_vec[r] = iss_en && (iss_addr == AW'(r));
            clr_vec[r] = (wa_en && (wa_addr == AW'(r))) ||
                         (wb_en && (wb_addr == AW'(r)));
        end
        busy_next = (busy & ~clr_vec) | set_vec;
        inc       = |(set_vec & ~busy);
        dec       = '0;
        for (int r = 1; r < NREGS; r++) begin
            dec = dec + {1'b0, busy[r] & clr_vec[r] & ~set_vec[r]};
        end
        busy_cnt_next = busy_cnt + CW'(inc) - CW'(dec);
        if (flush) begin
            busy_next     = '0;
            busy_cnt_next = '0;
        end
    end

    // Scoreboard state: busy bits and their population count, both cleared
    // asynchronously by reset so a reset mid-operation drops every mark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= busy_cnt_next;
        end
    end

    // Register storage. Writes to x0 are ignored (x0 is only ever reset to
    // zero). When both write ports target the same register, port B (the
    // CSR path) wins and port A's data is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wb_en && (wb_addr == AW'(r))) begin
                    regs[r] <= wb_data;
                end else if (wa_en && (wa_addr == AW'(r))) begin
                    regs[r] <= wa_data;
                end
            end
        end
    end

    // Read ports. Each port is purely combinational. With bypass enabled a
    // same-cycle write to the read address forwards its data (B over A) and
    // resolves the hazard immediately; otherwise the stored value is returned
    // and the busy bit alone decides the hazard. Address 0 always reads zero
    // and never stalls.
    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0]   addr;
        logic            hit_a;
        logic            hit_b;
        logic [XLEN-1:0] data;
        logic            haz;

        always_comb begin
            addr = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            hit_a = wa_en && (wa_addr == addr) && (addr != '0);
            hit_b = wb_en && (wb_addr == addr) && (addr != '0);
`else
            hit_a = 1'b0;
            hit_b = 1'b0;
`endif
            data = regs[addr];
            haz  = busy[addr] && !(hit_a || hit_b);
            if (hit_b) begin
                data = wb_data;
            end else if (hit_a) begin
                data = wa_data;
            end
            if (addr == '0) begin
                data = '0;
                haz  = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_hazard[i]            = haz;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//   Directed bench for regfile_sb with default parameters (XLEN=32, NREGS=32,
//   NREAD=2). Inputs are driven on the falling edge and outputs are checked
//   2 time units later, so every expectation describes the state committed by
//   earlier rising edges plus any same-cycle bypass. Expected values are
//   hand-computed; entries that differ with REGFILE_BYPASS_EN use BYP.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic            wa_en;
        logic [AW-1:0]   wa_addr;
        logic [XLEN-1:0] wa_data;
        logic            wb_en;
        logic [AW-1:0]   wb_addr;
        logic [XLEN-1:0] wb_data;
        logic            iss_en;
        logic [AW-1:0]   iss_addr;
        logic            flush;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic [XLEN-1:0] ed0;
        logic [XLEN-1:0] ed1;
        logic [1:0]      ehaz;
        logic [AW:0]     ecnt;
    } vec_t;

    logic                  clk;
    logic                  rst;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_hazard;
    logic                  wa_en;
    logic [AW-1:0]         wa_addr;
    logic [XLEN-1:0]       wa_data;
    logic                  wb_en;
    logic [AW-1:0]         wb_addr;
    logic [XLEN-1:0]       wb_data;
    logic                  iss_en;
    logic [AW-1:0]         iss_addr;
    logic                  flush;
    logic [AW:0]           busy_cnt;

    int tests;
    int fails;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    regfile_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_hazard (rd_hazard),
        .wa_en     (wa_en),
        .wa_addr   (wa_addr),
        .wa_data   (wa_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds one vector record from its inputs and expected outputs.
    function automatic vec_t mk(
        input logic            a_en, input logic [AW-1:0] a_ad, input logic [XLEN-1:0] a_d,
        input logic            b_en, input logic [AW-1:0] b_ad, input logic [XLEN-1:0] b_d,
        input logic            i_en, input logic [AW-1:0] i_ad, input logic fl,
        input logic [AW-1:0]   r0,   input logic [AW-1:0] r1,
        input logic [XLEN-1:0] e0,   input logic [XLEN-1:0] e1,
        input logic [1:0]      eh,   input logic [AW:0] ec);
        vec_t v;
        v.wa_en = a_en; v.wa_addr = a_ad; v.wa_data = a_d;
        v.wb_en = b_en; v.wb_addr = b_ad; v.wb_data = b_d;
        v.iss_en = i_en; v.iss_addr = i_ad; v.flush = fl;
        v.ra0 = r0; v.ra1 = r1;
        v.ed0 = e0; v.ed1 = e1; v.ehaz = eh; v.ecnt = ec;
        return v;
    endfunction

    // Drives one cycle of inputs on the falling edge and lets them settle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        wa_en    = v.wa_en;
        wa_addr  = v.wa_addr;
        wa_data  = v.wa_data;
        wb_en    = v.wb_en;
        wb_addr  = v.wb_addr;
        wb_data  = v.wb_data;
        iss_en   = v.iss_en;
        iss_addr = v.iss_addr;
        flush    = v.flush;
        rd_addr  = {v.ra1, v.ra0};
        #2;
    endtask

    // Compares all observable outputs against the record's expectations.
    task automatic checkOutput(input vec_t v, input string name);
        tests++;
        if (rd_data[XLEN-1:0] !== v.ed0) begin
            fails++;
            $display("[TB] FAIL %s rd_data0: got %h expected %h", name, rd_data[XLEN-1:0], v.ed0);
        end
        tests++;
        if (rd_data[2*XLEN-1:XLEN] !== v.ed1) begin
            fails++;
            $display("[TB] FAIL %s rd_data1: got %h expected %h", name, rd_data[2*XLEN-1:XLEN], v.ed1);
        end
        tests++;
        if (rd_hazard !== v.ehaz) begin
            fails++;
            $display("[TB] FAIL %s rd_hazard: got %b expected %b", name, rd_hazard, v.ehaz);
        end
        tests++;
        if (busy_cnt !== v.ecnt) begin
            fails++;
            $display("[TB] FAIL %s busy_cnt: got %0d expected %0d", name, busy_cnt, v.ecnt);
        end
    endtask

    // Applies a vector and checks it in one step.
    task automatic runVec(input vec_t v, input string name);
        applyStimulus(v);
        checkOutput(v, name);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Write/read, x0 write, dual-write collision, scoreboard, double
        // retire, write to non-busy register, issue to x0.
        vecs[0]  = mk(1, 7, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 7, 0,
                      BYP ? 32'hDEAD_BEEF : 32'h0, 32'h0, 2'b00, 0);
        vecs[1]  = mk(1, 0, 32'h1, 0, 0, 0, 0, 0, 0, 7, 0,
                      32'hDEAD_BEEF, 32'h0, 2'b00, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0,
                      32'hDEAD_BEEF, 32'h0, 2'b00, 0);
        vecs[3]  = mk(1, 9, 32'h1111, 1, 9, 32'h2222, 0, 0, 0, 9, 7,
                      BYP ? 32'h2222 : 32'h0, 32'hDEAD_BEEF, 2'b00, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9,
                      32'h2222, 32'h2222, 2'b00, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 9,
                      32'h0, 32'h2222, 2'b00, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0,
                      32'h0, 32'h0, 2'b01, 1);
        vecs[7]  = mk(1, 3, 32'h5, 0, 0, 0, 0, 0, 0, 3, 3,
                      BYP ? 32'h5 : 32'h0, BYP ? 32'h5 : 32'h0, BYP ? 2'b00 : 2'b11, 1);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0,
                      32'h5, 32'h0, 2'b00, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 10, 0, 10, 11,
                      32'h0, 32'h0, 2'b00, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 11, 0, 10, 11,
                      32'h0, 32'h0, 2'b01, 1);
        vecs[11] = mk(1, 10, 32'hAAAA, 1, 11, 32'hBBBB, 0, 0, 0, 10, 11,
                      BYP ? 32'hAAAA : 32'h0, BYP ? 32'hBBBB : 32'h0, BYP ? 2'b00 : 2'b11, 2);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 11,
                      32'hAAAA, 32'hBBBB, 2'b00, 0);
        vecs[13] = mk(0, 0, 0, 1, 12, 32'hC0DE, 0, 0, 0, 12, 0,
                      BYP ? 32'hC0DE : 32'h0, 32'h0, 2'b00, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0,
                      32'hC0DE, 32'h0, 2'b00, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 12, 0,
                      32'hC0DE, 32'h0, 2'b00, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12,
                      32'h0, 32'hC0DE, 2'b00, 0);

        // Reset held for two edges while a write to x5 is requested.
        rst      = 1'b1;
        wa_en    = 1'b1;
        wa_addr  = 5'd5;
        wa_data  = 32'hFFFF_FFFF;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
        rd_addr  = {5'd0, 5'd5};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        wa_en = 1'b0;
        #2;
        checkOutput(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'h0, 32'h0, 2'b00, 0), "reset");

        for (int i = 0; i < NVEC; i++) begin
            runVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Set and clear of x4 in the same cycle keeps it busy.
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 4, 0, 32'h0, 32'h0, 2'b00, 0), "race_iss");
        runVec(mk(1, 4, 32'h77, 0, 0, 0, 1, 4, 0, 4, 4,
                  BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0, BYP ? 2'b00 : 2'b11, 1), "race_both");
        runVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 32'h77, 32'h0, 2'b01, 1), "race_still_busy");
        runVec(mk(1, 4, 32'h78, 0, 0, 0, 0, 0, 0, 4, 0,
                  BYP ? 32'h78 : 32'h77, 32'h0, BYP ? 2'b00 : 2'b01, 1), "race_retire");
        runVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 32'h78, 32'h0, 2'b00, 0), "race_done");

        // Three issues then a flush that also carries an issue to x6.
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 6, 32'h0, 32'h0, 2'b00, 0), "flush_iss1");
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 6, 32'h0, 32'h0, 2'b01, 1), "flush_iss2");
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 2, 3, 32'h0, 32'h5, 2'b01, 2), "flush_iss3");
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 6, 1, 1, 6, 32'h0, 32'h0, 2'b01, 3), "flush_cycle");
        runVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 3, 32'h0, 32'h5, 2'b00, 0), "flush_after_a");
        runVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h0, 32'h0, 2'b00, 0), "flush_after_b");

        // Asynchronous reset mid-operation clears data and scoreboard at once.
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 8, 0, 8, 7, 32'h0, 32'hDEAD_BEEF, 2'b00, 0), "arst_iss");
        runVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 7, 32'h0, 32'hDEAD_BEEF, 2'b01, 1), "arst_busy");
        @(negedge clk);
        rst = 1'b1;
        #2;
        checkOutput(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 7, 32'h0, 32'h0, 2'b00, 0), "arst_async");
        @(negedge clk);
        rst = 1'b0;
        runVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 8, 32'h0, 32'h0, 2'b00, 0), "arst_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
